// File: rtl/memory_responder.sv
// SRAM / memory-mapped I/O responder for the eLC-3 RAM port.
// A request runs a multi-cycle SRAM access (or a one-cycle I/O access), then holds R until MIO_EN drops.
module memory_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Address,
  input  logic [15:0] Data_In,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] Data_Out,
  output logic        R,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_Out,
  input  logic [15:0] SRAM_DQ_In,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [15:0] Switches,
  output logic [15:0] HexDisplay
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] hex_q, hex_d;
  logic        rw_q, rw_d;
  logic        io_q, io_d;
  logic        is_io_addr;
  logic        sram_cycle;

  assign is_io_addr = (Address == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      dout_q  <= 16'h0000;
      hex_q   <= 16'h0000;
      rw_q    <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      hex_q   <= hex_d;
      rw_q    <= rw_d;
      io_q    <= io_d;
    end
  end

  // I/O requests pass through ACCESS for one cycle (counter 0) with strobes gated off,
  // so their completion lands one edge after the request edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    hex_d   = hex_q;
    rw_d    = rw_q;
    io_d    = io_q;
    unique case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          addr_d  = Address;
          wdata_d = Data_In;
          rw_d    = R_W;
          io_d    = is_io_addr;
          cnt_d   = is_io_addr ? 4'd0 : WAIT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = READY;
          if (io_q) begin
            if (rw_q) hex_d = wdata_q;
            else      dout_d = Switches;
          end else if (!rw_q) begin
            dout_d = SRAM_DQ_In;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        if (!MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode registered state only; WE_N releases on the final cycle for hold time.
  assign sram_cycle  = (state_q == ACCESS) && !io_q;
  assign SRAM_CE_N   = !sram_cycle;
  assign SRAM_OE_N   = !(sram_cycle && !rw_q);
  assign SRAM_WE_N   = !(sram_cycle && rw_q && (cnt_q != 4'd0));
  assign SRAM_DQ_OE  = sram_cycle && rw_q;
  assign R           = (state_q == READY);
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_Out = wdata_q;
  assign Data_Out    = dout_q;
  assign HexDisplay  = hex_q;

endmodule
